// File: rtl/sdf_flux_scheduler.sv
// Firing controller for a multi-flux SDF actor shared between FLUX token streams.
// A round-robin arbiter grants a flux whose input FIFOs all hold a token, pops one
// token per port, fires the actor with that flux's configured operation, waits for
// the result and pushes it, flux-tagged, into the single output FIFO.
// Optional macro SDF_SCHED_STATS_EN adds per-flux completed-write counters
// (fire_cnt) with a synchronous clear (stats_clr).
module sdf_flux_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int FLUX       = 2,
  parameter int PORTS      = 2,
  parameter int NUM_OP     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [FLUX*PORTS-1:0]                 empty,
  output logic [FLUX*PORTS-1:0]                 read,
  input  logic                                  full,
  output logic                                  write,
  output logic [DATA_WIDTH+$clog2(FLUX)-1:0]    din,
  output logic                                  fire,
  output logic [$clog2(FLUX)-1:0]               fire_flux,
  output logic [$clog2(NUM_OP)-1:0]             op_sel,
  input  logic                                  res_valid,
  input  logic [DATA_WIDTH-1:0]                 res_data,
  input  logic                                  cfg_we,
  input  logic [$clog2(FLUX)-1:0]               cfg_flux,
  input  logic [$clog2(NUM_OP)-1:0]             cfg_op,
  output logic                                  busy
`ifdef SDF_SCHED_STATS_EN
  ,
  output logic [FLUX*16-1:0]                    fire_cnt,
  input  logic                                  stats_clr
`endif
);

  localparam int FW = $clog2(FLUX);
  localparam int OW = $clog2(NUM_OP);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  state_t                state_q, state_d;
  logic [FW-1:0]         grant_q, grant_d;
  logic [FW-1:0]         last_q, last_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [OW-1:0]         optable_q [FLUX];
  logic [OW-1:0]         optable_d [FLUX];

  logic [FLUX-1:0]       elig;
  logic                  found;
  logic [FW-1:0]         pick;
  logic [FW-1:0]         cand;
  int unsigned           idx;

  // Eligibility per flux and round-robin search starting just after last_q
  always_comb begin
    elig  = '1;
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int unsigned f = 0; f < FLUX; f++) begin
      for (int unsigned p = 0; p < PORTS; p++) begin
        if (empty[p*FLUX+f]) elig[f] = 1'b0;
      end
    end
    for (int unsigned i = 1; i <= FLUX; i++) begin
      idx  = (32'(last_q) + i) % FLUX;
      cand = FW'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state logic and register updates for the firing sequence
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = READ;
        end
      end
      READ: state_d = EXEC;
      EXEC: begin
        if (res_valid) begin
          res_d   = res_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!full) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state; only write looks at full
  always_comb begin
    read      = '0;
    fire      = 1'b0;
    fire_flux = '0;
    op_sel    = '0;
    write     = 1'b0;
    din       = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      READ: begin
        for (int unsigned p = 0; p < PORTS; p++) begin
          read[p*FLUX + 32'(grant_q)] = 1'b1;
        end
        fire      = 1'b1;
        fire_flux = grant_q;
        op_sel    = optable_q[grant_q];
      end
      WRITE: begin
        din   = {grant_q, res_q};
        write = !full;
      end
      default: ;
    endcase
  end

  // Op-table update; out-of-range index or value is dropped
  always_comb begin
    optable_d = optable_q;
    if (cfg_we && (32'(cfg_flux) < FLUX) && (32'(cfg_op) < NUM_OP)) begin
      optable_d[cfg_flux] = cfg_op;
    end
  end

  // Control and op-table registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= FW'(FLUX-1);
      res_q   <= '0;
      for (int unsigned f = 0; f < FLUX; f++) optable_q[f] <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      res_q     <= res_d;
      optable_q <= optable_d;
    end
  end

`ifdef SDF_SCHED_STATS_EN
  logic [FLUX*16-1:0] cnt_q, cnt_d;

  // Per-flux completed-write counters; clear beats a same-cycle increment
  always_comb begin
    cnt_d = cnt_q;
    if (stats_clr) begin
      cnt_d = '0;
    end else if (write) begin
      cnt_d[32'(grant_q)*16 +: 16] = cnt_q[32'(grant_q)*16 +: 16] + 16'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign fire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sdf_flux_scheduler.sv
// Self-checking bench for sdf_flux_scheduler: directed table of single firings,
// hand-written multi-cycle corner cases and a randomized run checked against a
// token-count round-robin model.
module tb_sdf_flux_scheduler;

  localparam int DW   = 8;
  localparam int FLUX = 2;
  localparam int PORTS = 2;
  localparam int NOP  = 2;
  localparam int FW   = $clog2(FLUX);
  localparam int OW   = $clog2(NOP);
  localparam int NP   = FLUX*PORTS;

  logic clk = 0;
  logic rst;
  logic [NP-1:0]    empty;
  logic [NP-1:0]    read;
  logic             full;
  logic             write;
  logic [DW+FW-1:0] din;
  logic             fire;
  logic [FW-1:0]    fire_flux;
  logic [OW-1:0]    op_sel;
  logic             res_valid;
  logic [DW-1:0]    res_data;
  logic             cfg_we;
  logic [FW-1:0]    cfg_flux;
  logic [OW-1:0]    cfg_op;
  logic             busy;
`ifdef SDF_SCHED_STATS_EN
  logic [FLUX*16-1:0] fire_cnt;
  logic               stats_clr;
`endif

  sdf_flux_scheduler #(.DATA_WIDTH(DW), .FLUX(FLUX), .PORTS(PORTS), .NUM_OP(NOP)) dut (
    .clk(clk), .rst(rst), .empty(empty), .read(read), .full(full), .write(write),
    .din(din), .fire(fire), .fire_flux(fire_flux), .op_sel(op_sel),
    .res_valid(res_valid), .res_data(res_data), .cfg_we(cfg_we), .cfg_flux(cfg_flux),
    .cfg_op(cfg_op), .busy(busy)
`ifdef SDF_SCHED_STATS_EN
    , .fire_cnt(fire_cnt), .stats_clr(stats_clr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Options for do_fire: op-table write driven in the READ cycle
  bit            cfg_at_fire = 0;
  logic [FW-1:0] cfg_at_f;
  logic [OW-1:0] cfg_at_o;

  typedef struct {
    logic [NP-1:0] pat;
    logic [DW-1:0] data;
    logic [FW-1:0] exp_f;
    logic [OW-1:0] exp_o;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP-1:0] mask(input int f);
    logic [NP-1:0] m;
    m = '0;
    for (int p = 0; p < PORTS; p++) m[p*FLUX+f] = 1'b1;
    return m;
  endfunction

  task automatic cfg_write(input int f, input int o);
    cfg_we = 1; cfg_flux = FW'(f); cfg_op = OW'(o);
    step();
    cfg_we = 0;
  endtask

  // One complete firing: wait for fire, answer after lat EXEC cycles, stall WRITE
  task automatic do_fire(input logic [NP-1:0] pat, input logic [DW-1:0] data,
                         input int lat, input int stall, input bit hold,
                         input logic [FW-1:0] exp_f, input logic [OW-1:0] exp_o);
    bit got;
    logic [DW+FW-1:0] exp_din;
    got = 0;
    exp_din = {exp_f, data};
    empty = pat;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (fire) got = 1;
    end
    if (!got) begin
      check("fire_timeout", {31'd0, fire}, 32'd1);
      empty = '1;
      return;
    end
    if (cfg_at_fire) begin
      cfg_we = 1; cfg_flux = cfg_at_f; cfg_op = cfg_at_o;
      #1;
    end
    check("fire_flux", 32'(fire_flux), 32'(exp_f));
    check("op_sel", 32'(op_sel), 32'(exp_o));
    check("read_mask", 32'(read), 32'(mask(int'(exp_f))));
    if (!hold) empty = '1;
    step();
    cfg_we = 0;
    check("fire_one_cycle", {31'd0, fire}, 32'd0);
    if (stall > 0) full = 1;
    repeat (lat-1) step();
    res_valid = 1; res_data = data;
    step();
    res_valid = 0;
    for (int i = 0; i < stall; i++) begin
      check("stall_write", {31'd0, write}, 32'd0);
      check("stall_din", 32'(din), 32'(exp_din));
      step();
    end
    full = 0;
    #1;
    check("write", {31'd0, write}, 32'd1);
    check("din", 32'(din), 32'(exp_din));
    step();
    check("write_single", {31'd0, write}, 32'd0);
  endtask

  // Randomized phase state
  int cnt [PORTS][FLUX];
  int exp_fq[$];
  logic [DW+FW-1:0] exp_dq[$];
  logic [OW-1:0] optab_m [FLUX];

  task automatic random_run();
    int m_cnt [PORTS][FLUX];
    int last, total, nw, lat, cur_f, ef, mn;
    bit pend, done;
    logic [DW-1:0] d;
    rst = 1; step(); rst = 0;
    for (int f = 0; f < FLUX; f++) begin
      optab_m[f] = OW'($urandom_range(0, NOP-1));
      cfg_write(f, int'(optab_m[f]));
    end
    for (int p = 0; p < PORTS; p++)
      for (int f = 0; f < FLUX; f++) begin
        cnt[p][f] = $urandom_range(0, 6);
        m_cnt[p][f] = cnt[p][f];
      end
    // Expected grant order: round robin over fluxes that still have a token on every port
    last = FLUX-1; total = 0;
    forever begin
      ef = -1;
      for (int i = 1; i <= FLUX && ef < 0; i++) begin
        mn = 1000;
        for (int p = 0; p < PORTS; p++)
          if (m_cnt[p][(last+i)%FLUX] < mn) mn = m_cnt[p][(last+i)%FLUX];
        if (mn > 0) ef = (last+i)%FLUX;
      end
      if (ef < 0) break;
      for (int p = 0; p < PORTS; p++) m_cnt[p][ef]--;
      exp_fq.push_back(ef);
      last = ef; total++;
    end
    for (int p = 0; p < PORTS; p++)
      for (int f = 0; f < FLUX; f++) empty[p*FLUX+f] = (cnt[p][f] == 0);
    pend = 0; nw = 0; done = 0; lat = 0; cur_f = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (fire) begin
        if (exp_fq.size() == 0) begin
          check("rnd_extra_fire", {31'd0, fire}, 32'd0);
          cur_f = int'(fire_flux);
        end else begin
          cur_f = exp_fq.pop_front();
          check("rnd_fire_flux", 32'(fire_flux), 32'(cur_f));
          check("rnd_op_sel", 32'(op_sel), 32'(optab_m[cur_f]));
          check("rnd_read", 32'(read), 32'(mask(cur_f)));
        end
        for (int p = 0; p < PORTS; p++) if (cnt[p][cur_f] > 0) cnt[p][cur_f]--;
        pend = 1; lat = $urandom_range(1, 4);
      end
      for (int p = 0; p < PORTS; p++)
        for (int f = 0; f < FLUX; f++) empty[p*FLUX+f] = (cnt[p][f] == 0);
      full = ($urandom_range(0, 2) == 0);
      res_valid = 0;
      if (pend && !fire) begin
        lat--;
        if (lat == 0) begin
          d = DW'($urandom);
          res_valid = 1; res_data = d;
          exp_dq.push_back({FW'(cur_f), d});
          pend = 0;
        end
      end else if (!pend && $urandom_range(0, 7) == 0) begin
        res_valid = 1; res_data = DW'($urandom);
      end
      #1;
      if (write) begin
        if (exp_dq.size() == 0) check("rnd_extra_write", {31'd0, write}, 32'd0);
        else check("rnd_din", 32'(din), 32'(exp_dq.pop_front()));
        nw++;
      end
      if (nw == total && exp_fq.size() == 0 && !busy && !pend) done = 1;
    end
    check("rnd_complete", {31'd0, done}, 32'd1);
    check("rnd_writes", 32'(nw), 32'(total));
    full = 0; res_valid = 0; empty = '1;
    step();
  endtask

  vec_t vecs [5];
  bit got;

  initial begin
    vecs[0] = '{pat: 4'b1010, data: 8'h5A, exp_f: 1'b0, exp_o: 1'b1};
    vecs[1] = '{pat: 4'b0000, data: 8'hC3, exp_f: 1'b1, exp_o: 1'b0};
    vecs[2] = '{pat: 4'b0000, data: 8'h11, exp_f: 1'b0, exp_o: 1'b1};
    vecs[3] = '{pat: 4'b0101, data: 8'hFF, exp_f: 1'b1, exp_o: 1'b0};
    vecs[4] = '{pat: 4'b1010, data: 8'h00, exp_f: 1'b0, exp_o: 1'b1};

    rst = 1; empty = '1; full = 0; res_valid = 0; res_data = '0;
    cfg_we = 0; cfg_flux = '0; cfg_op = '0;
`ifdef SDF_SCHED_STATS_EN
    stats_clr = 0;
`endif
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_fire", {31'd0, fire}, 32'd0);
    check("rst_din", 32'(din), 32'd0);
    rst = 0;
    step();

    cfg_write(0, 1);
    for (int i = 0; i < 5; i++)
      do_fire(vecs[i].pat, vecs[i].data, 1, 0, 0, vecs[i].exp_f, vecs[i].exp_o);

    // Reset while in EXEC: outputs drop at once, late result ignored, search restarts at 0
    empty = 4'b1010;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (fire) got = 1;
    end
    check("pre_rst_fire", {31'd0, got}, 32'd1);
    empty = '1;
    step();
    check("exec_busy", {31'd0, busy}, 32'd1);
    rst = 1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_read", 32'(read), 32'd0);
    check("mid_rst_fire", {31'd0, fire}, 32'd0);
    check("mid_rst_write", {31'd0, write}, 32'd0);
    check("mid_rst_din", 32'(din), 32'd0);
    check("mid_rst_ffl", 32'(fire_flux), 32'd0);
    check("mid_rst_op", 32'(op_sel), 32'd0);
    step(); step();
    rst = 0;
    res_valid = 1; res_data = 8'h77;
    step();
    res_valid = 0;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_write", {31'd0, write}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      step();
    end

    // Both fluxes eligible for four firings; op table was cleared by reset
    do_fire(4'b0000, 8'h01, 2, 0, 1, 1'b0, 1'b0);
    do_fire(4'b0000, 8'h02, 1, 0, 1, 1'b1, 1'b0);
    do_fire(4'b0000, 8'h03, 3, 0, 1, 1'b0, 1'b0);
    do_fire(4'b0000, 8'h04, 1, 0, 0, 1'b1, 1'b0);
    step();

    // Output FIFO full for 5 cycles in WRITE
    do_fire(4'b1010, 8'h33, 1, 5, 0, 1'b0, 1'b0);

    // Only port 0 of flux 0 holds a token: nothing happens
    empty = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      step();
      check("partial_read", 32'(read), 32'd0);
      check("partial_fire", {31'd0, fire}, 32'd0);
      check("partial_busy", {31'd0, busy}, 32'd0);
    end
    empty = '1;

    // Op-table write during READ of the same entry: old value now, new value next firing
    cfg_at_fire = 1; cfg_at_f = 1'b1; cfg_at_o = 1'b1;
    do_fire(4'b0101, 8'hA5, 1, 0, 0, 1'b1, 1'b0);
    cfg_at_fire = 0;
    do_fire(4'b0101, 8'h5A, 1, 0, 0, 1'b1, 1'b1);

    random_run();
    random_run();

`ifdef SDF_SCHED_STATS_EN
    rst = 1; step(); rst = 0; step();
    for (int i = 0; i < 3; i++) do_fire(4'b0101, 8'h10, 1, 0, 0, 1'b1, 1'b0);
    check("cnt_f1", 32'(fire_cnt[31:16]), 32'd3);
    check("cnt_f0", 32'(fire_cnt[15:0]), 32'd0);
    stats_clr = 1;
    step();
    stats_clr = 0;
    check("cnt_clr", 32'(fire_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
